time_counter: RTL and testbench
===============================

# time_counter

Time-of-day register bank for the digital clock, downstream of the mode-select state machine. Holds hours, minutes and seconds as BCD digits for the display drivers. Advances on a once-per-second tick in run mode. While the mode FSM asserts one of its modify outputs, time is frozen and each press of the increment button steps the selected field.

## Interface

- HOUR_MAX, default 23: highest hour value before the hours field wraps to 0. Legal range is 1..23.
- clk  input  1  system clock; every flop is rising-edge clocked.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle enable pulse, once per second.
- inc  input  1  increment button level, already synchronized and debounced.
- ms  input  1  modify-seconds select from the mode FSM.
- mm  input  1  modify-minutes select from the mode FSM.
- mh  input  1  modify-hours select from the mode FSM.
- s_ones  output  4  seconds ones digit, BCD 0–9.
- s_tens  output  3  seconds tens digit, 0–5.
- m_ones  output  4  minutes ones digit, BCD 0–9.
- m_tens  output  3  minutes tens digit, 0–5.
- h_ones  output  4  hours ones digit, BCD 0–9.
- h_tens  output  2  hours tens digit, 0–2.
- day_wrap  output  1  one-cycle pulse when run-mode counting wraps HOUR_MAX:59:59 to 00:00:00.

## Operation

- **Mode decode**
  - Run mode: ms = mm = mh = 0.
  - Set mode: any select is high.
  - Several selects high is illegal from the FSM, but is defined: priority mh > mm > ms.
- **Increment edge**
  - inc_q is a registered copy of inc.
  - inc_edge = inc & ~inc_q.
  - inc_q resets to 1, so a button held through reset does not produce an edge.
- **Run mode**
  - tick = 1 advances seconds by one.
  - Seconds 59 → 00 carries +1 into minutes.
  - Minutes 59 → 00 carries +1 into hours.
  - Hours HOUR_MAX → 00.
  - The full cascade completes in a single cycle.
  - inc_edge is ignored.
- **Set mode**
  - tick is ignored; time is frozen.
  - inc_edge adds +1 to the selected field only.
  - The selected field wraps (59 → 00, or HOUR_MAX → 00) with no carry into the next field.
  - A field never holds an illegal value: ones digit > 9, minutes/seconds > 59, or hours > HOUR_MAX.
- **BCD arithmetic**
  - Ones digit 9 → 0 with +1 into the tens digit.
  - Hours compare the full two-digit value against HOUR_MAX (e.g. 23 → 00, not 29).
- **day_wrap**
  - Asserted only on the run-mode tick that wraps the whole time.
  - Never asserted by a set-mode wrap.
- **Reset**
  - rst = 1 on a clock edge: all digits 0, day_wrap 0, inc_q 1.
  - Overrides tick and inc_edge in the same cycle, including reset mid-cascade.

## Timing

- All outputs are registered.
- A tick or inc_edge sampled at edge N is visible on the outputs after edge N.
- day_wrap is high for exactly the cycle following the wrapping tick.
- inc rising at edge N produces exactly one increment at edge N, regardless of how long inc stays high.
- The next increment needs inc to fall, then rise again; the minimum pulse is one cycle high and one cycle low.
- Mode change is combinational on the inputs: a tick in the same cycle the selects drop to 0 counts.
- An inc_edge in the same cycle mh rises applies to hours.
- Simultaneous tick and inc_edge:
  - In run mode, only the tick acts.
  - In set mode, only the inc_edge acts.

## Test plan

- **Reset:** assert rst for 2 cycles while tick = 1 and inc toggles -> all digits 0, day_wrap 0; hold inc = 1 across rst release -> no increment.
- **Full wrap:**
  - Use set mode to load 23:59:59, then return to run mode and pulse tick -> 00:00:00.
  - day_wrap is high for exactly 1 cycle.
- **Minute carry:** from 00:00:58, give 2 ticks -> 00:00:59, then 00:01:00; day_wrap stays 0.
- **Set seconds wrap:**
  - With ms = 1 at 00:07:59, one inc press -> 00:07:00; minutes unchanged.
  - 5 ticks during set mode -> time unchanged.
- **Edge detect:**
  - mm = 1; hold inc high for 10 cycles -> minutes +1 only.
  - 3 separate presses from 00:58:00 -> 00:58 → 00:59 → 00:00 → 00:01, with hours still 00.
- **Hours and priority:**
  - With HOUR_MAX = 11 at 11:xx:xx, mh = 1, one press -> hours 00.
  - With mm = mh = 1, one press -> hours change, minutes unchanged.

Source files
------------

// File: rtl/time_counter.sv
// Time-of-day register bank: BCD hours/minutes/seconds for the display drivers.
// Counts on the one-second tick in run mode; in set mode the time is frozen and each
// rising edge of the increment button steps the field chosen by the mode FSM.
module time_counter #(
   parameter int unsigned HOUR_MAX = 23
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic       inc_i,
   input  logic       ms_i,
   input  logic       mm_i,
   input  logic       mh_i,
   output logic [3:0] s_ones_o,
   output logic [2:0] s_tens_o,
   output logic [3:0] m_ones_o,
   output logic [2:0] m_tens_o,
   output logic [3:0] h_ones_o,
   output logic [1:0] h_tens_o,
   output logic       day_wrap_o
);

   localparam logic [4:0] HourMaxL = 5'(HOUR_MAX);

   logic [3:0] s_ones_q, s_ones_d;
   logic [2:0] s_tens_q, s_tens_d;
   logic [3:0] m_ones_q, m_ones_d;
   logic [2:0] m_tens_q, m_tens_d;
   logic [3:0] h_ones_q, h_ones_d;
   logic [1:0] h_tens_q, h_tens_d;
   logic       day_wrap_q, day_wrap_d;
   logic       inc_q;

   logic       run_mode;
   logic       inc_edge;
   logic       sec_last, min_last, hour_last;
   logic       step_sec, step_min, step_hour;
   logic [4:0] hour_val;

   assign run_mode = ~(ms_i | mm_i | mh_i);
   assign inc_edge = inc_i & ~inc_q;

   // ">=" keeps the fields self-correcting should a digit ever hold an out-of-range value.
   assign sec_last  = (s_tens_q >= 3'd5) && (s_ones_q >= 4'd9);
   assign min_last  = (m_tens_q >= 3'd5) && (m_ones_q >= 4'd9);
   assign hour_val  = ({3'b000, h_tens_q} * 5'd10) + {1'b0, h_ones_q};
   assign hour_last = (hour_val >= HourMaxL);

   // Decide which fields step this cycle: tick cascade in run mode, single field in set mode.
   always_comb begin
      step_sec   = 1'b0;
      step_min   = 1'b0;
      step_hour  = 1'b0;
      day_wrap_d = 1'b0;
      if (run_mode) begin
         step_sec   = tick_i;
         step_min   = tick_i & sec_last;
         step_hour  = tick_i & sec_last & min_last;
         day_wrap_d = tick_i & sec_last & min_last & hour_last;
      end else begin
         // mh > mm > ms when the FSM drives more than one select.
         step_hour = inc_edge & mh_i;
         step_min  = inc_edge & mm_i & ~mh_i;
         step_sec  = inc_edge & ms_i & ~mm_i & ~mh_i;
      end
   end

   // BCD next-state for seconds and minutes (wrap at 59, no carry out here).
   always_comb begin
      s_ones_d = s_ones_q;
      s_tens_d = s_tens_q;
      m_ones_d = m_ones_q;
      m_tens_d = m_tens_q;
      if (step_sec) begin
         if (sec_last) begin
            s_ones_d = 4'd0;
            s_tens_d = 3'd0;
         end else if (s_ones_q >= 4'd9) begin
            s_ones_d = 4'd0;
            s_tens_d = s_tens_q + 3'd1;
         end else begin
            s_ones_d = s_ones_q + 4'd1;
         end
      end
      if (step_min) begin
         if (min_last) begin
            m_ones_d = 4'd0;
            m_tens_d = 3'd0;
         end else if (m_ones_q >= 4'd9) begin
            m_ones_d = 4'd0;
            m_tens_d = m_tens_q + 3'd1;
         end else begin
            m_ones_d = m_ones_q + 4'd1;
         end
      end
   end

   // BCD next-state for hours; wrap compares the full two-digit value against HOUR_MAX.
   always_comb begin
      h_ones_d = h_ones_q;
      h_tens_d = h_tens_q;
      if (step_hour) begin
         if (hour_last) begin
            h_ones_d = 4'd0;
            h_tens_d = 2'd0;
         end else if (h_ones_q >= 4'd9) begin
            h_ones_d = 4'd0;
            h_tens_d = h_tens_q + 2'd1;
         end else begin
            h_ones_d = h_ones_q + 4'd1;
         end
      end
   end

   // State registers; inc_q resets high so a button held through reset gives no edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_ones_q   <= 4'd0;
         s_tens_q   <= 3'd0;
         m_ones_q   <= 4'd0;
         m_tens_q   <= 3'd0;
         h_ones_q   <= 4'd0;
         h_tens_q   <= 2'd0;
         day_wrap_q <= 1'b0;
         inc_q      <= 1'b1;
      end else begin
         s_ones_q   <= s_ones_d;
         s_tens_q   <= s_tens_d;
         m_ones_q   <= m_ones_d;
         m_tens_q   <= m_tens_d;
         h_ones_q   <= h_ones_d;
         h_tens_q   <= h_tens_d;
         day_wrap_q <= day_wrap_d;
         inc_q      <= inc_i;
      end
   end

   assign s_ones_o   = s_ones_q;
   assign s_tens_o   = s_tens_q;
   assign m_ones_o   = m_ones_q;
   assign m_tens_o   = m_tens_q;
   assign h_ones_o   = h_ones_q;
   assign h_tens_o   = h_tens_q;
   assign day_wrap_o = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: a vector table plus model-driven sequences,
// with expected results queued at drive time and compared after the clock edge.
module tb_time_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tick, inc, ms, mm, mh;
   logic [3:0] s_ones, m_ones, h_ones;
   logic [2:0] s_tens, m_tens;
   logic [1:0] h_tens;
   logic       day_wrap;

   logic       b_rst, b_tick, b_inc, b_ms, b_mm, b_mh;
   logic [3:0] b_s_ones, b_m_ones, b_h_ones;
   logic [2:0] b_s_tens, b_m_tens;
   logic [1:0] b_h_tens;
   logic       b_day_wrap;

   time_counter #(.HOUR_MAX(23)) dut (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .inc_i(inc),
      .ms_i(ms), .mm_i(mm), .mh_i(mh),
      .s_ones_o(s_ones), .s_tens_o(s_tens), .m_ones_o(m_ones), .m_tens_o(m_tens),
      .h_ones_o(h_ones), .h_tens_o(h_tens), .day_wrap_o(day_wrap)
   );

   time_counter #(.HOUR_MAX(11)) dut_b (
      .clk_i(clk), .rst_i(b_rst), .tick_i(b_tick), .inc_i(b_inc),
      .ms_i(b_ms), .mm_i(b_mm), .mh_i(b_mh),
      .s_ones_o(b_s_ones), .s_tens_o(b_s_tens), .m_ones_o(b_m_ones), .m_tens_o(b_m_tens),
      .h_ones_o(b_h_ones), .h_tens_o(b_h_tens), .day_wrap_o(b_day_wrap)
   );

   typedef struct {
      int    h;
      int    m;
      int    s;
      logic  dw;
      string name;
   } exp_t;

   typedef struct {
      logic  r, t, i, s, m, h;
      int    eh, em, es;
      logic  edw;
      string name;
   } vec_t;

   exp_t sb_q[$];
   vec_t vt[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   th, tm, ts;
   logic inc_prev;

   function automatic logic [19:0] to_bcd(int h, int m, int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   task automatic sb_compare();
      exp_t       e;
      logic [19:0] act, want;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard_empty: got no expected entry, want one");
         return;
      end
      e    = sb_q.pop_front();
      act  = {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones};
      want = to_bcd(e.h, e.m, e.s);
      if (act !== want || day_wrap !== e.dw) begin
         n_err++;
         $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d day_wrap=%b, want %02d:%02d:%02d day_wrap=%b",
                  e.name, h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, day_wrap,
                  e.h, e.m, e.s, e.dw);
      end
   endtask

   task automatic apply(input logic r, t, i, s, m, h, input int eh, em, es,
                        input logic edw, input string name);
      exp_t e;
      @(negedge clk);
      rst = r; tick = t; inc = i; ms = s; mm = m; mh = h;
      e.h = eh; e.m = em; e.s = es; e.dw = edw; e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      sb_compare();
   endtask

   // Integer reference model of one clock cycle, then drive and queue its expectation.
   task automatic step(input logic r, t, i, s, m, h, input string name);
      logic edge_v, dw;
      edge_v = i & ~inc_prev;
      dw     = 1'b0;
      if (r) begin
         th = 0; tm = 0; ts = 0;
      end else if (!(s | m | h)) begin
         if (t) begin
            ts++;
            if (ts == 60) begin
               ts = 0; tm++;
               if (tm == 60) begin
                  tm = 0; th++;
                  if (th > 23) begin
                     th = 0; dw = 1'b1;
                  end
               end
            end
         end
      end else if (edge_v) begin
         if (h)      th = (th == 23) ? 0 : th + 1;
         else if (m) tm = (tm + 1) % 60;
         else        ts = (ts + 1) % 60;
      end
      inc_prev = r ? 1'b1 : i;
      apply(r, t, i, s, m, h, th, tm, ts, dw, name);
   endtask

   task automatic press(input logic s, m, h, input string name);
      step(1'b0, 1'b0, 1'b1, s, m, h, name);
      step(1'b0, 1'b0, 1'b0, s, m, h, name);
   endtask

   task automatic add(input logic r, t, i, s, m, h, input int eh, em, es,
                      input logic edw, input string name);
      vec_t v;
      v.r = r; v.t = t; v.i = i; v.s = s; v.m = m; v.h = h;
      v.eh = eh; v.em = em; v.es = es; v.edw = edw; v.name = name;
      vt.push_back(v);
   endtask

   task automatic check_b(input string name, input logic [1:0] et, input logic [3:0] eo);
      n_cmp++;
      if (b_h_tens !== et || b_h_ones !== eo || b_day_wrap !== 1'b0) begin
         n_err++;
         $display("FAIL %s: got hours %0d%0d day_wrap=%b, want %0d%0d day_wrap=0",
                  name, b_h_tens, b_h_ones, b_day_wrap, et, eo);
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; inc = 1'b0; ms = 1'b0; mm = 1'b0; mh = 1'b0;
      b_rst = 1'b1; b_tick = 1'b0; b_inc = 1'b0; b_ms = 1'b0; b_mm = 1'b0; b_mh = 1'b0;

      //  r  t  i  ms mm mh   h  m  s  dw
      add(1, 1, 1, 0, 0, 0,   0, 0, 0, 0, "rst_tick_inc_hi");
      add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "rst_tick_inc_lo");
      add(1, 1, 1, 0, 0, 0,   0, 0, 0, 0, "rst_inc_held");
      add(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, "inc_held_thru_reset");
      add(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, "inc_still_held");
      add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, "inc_released");
      add(0, 0, 1, 1, 0, 0,   0, 0, 1, 0, "set_sec_press");
      add(0, 1, 0, 1, 0, 0,   0, 0, 1, 0, "tick_frozen_in_set");
      add(0, 1, 0, 0, 0, 0,   0, 0, 2, 0, "run_tick");
      add(0, 0, 0, 0, 0, 0,   0, 0, 2, 0, "run_idle");
      add(0, 1, 1, 0, 0, 0,   0, 0, 3, 0, "run_tick_ignores_inc");
      add(0, 0, 0, 0, 1, 0,   0, 0, 3, 0, "set_min_idle");
      add(0, 1, 1, 0, 1, 0,   0, 1, 3, 0, "set_inc_beats_tick");
      add(0, 0, 0, 0, 1, 1,   0, 1, 3, 0, "prio_idle");
      add(0, 0, 1, 0, 1, 1,   1, 1, 3, 0, "prio_mh_over_mm");
      add(0, 0, 0, 0, 0, 0,   1, 1, 3, 0, "back_to_run");
      add(0, 0, 1, 0, 0, 1,   2, 1, 3, 0, "inc_with_mh_rise");
      add(0, 1, 0, 0, 0, 0,   2, 1, 4, 0, "tick_as_selects_drop");
      add(1, 1, 1, 0, 0, 1,   0, 0, 0, 0, "rst_overrides_all");

      for (int k = 0; k < vt.size(); k++) begin
         apply(vt[k].r, vt[k].t, vt[k].i, vt[k].s, vt[k].m, vt[k].h,
               vt[k].eh, vt[k].em, vt[k].es, vt[k].edw, vt[k].name);
      end
      th = 0; tm = 0; ts = 0; inc_prev = 1'b1;

      // Minute carry from 00:00:58.
      step(0, 0, 0, 0, 0, 0, "release_inc");
      for (int k = 0; k < 58; k++) press(1, 0, 0, "load_sec58");
      step(0, 1, 0, 0, 0, 0, "tick_to_59");
      step(0, 1, 0, 0, 0, 0, "minute_carry");

      // Seconds wrap in set mode from 00:07:59, then ticks frozen.
      for (int k = 0; k < 6; k++) press(0, 1, 0, "load_min7");
      for (int k = 0; k < 59; k++) press(1, 0, 0, "load_sec59");
      press(1, 0, 0, "set_sec_wrap_no_carry");
      for (int k = 0; k < 5; k++) step(0, 1, 0, 1, 0, 0, "ticks_frozen");

      // Long press counts once, then 00:58 -> 00:59 -> 00:00 -> 00:01 without hour carry.
      for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 1, 0, "long_press");
      step(0, 0, 0, 0, 1, 0, "long_press_release");
      while (tm != 58) press(0, 1, 0, "load_min58");
      for (int k = 0; k < 3; k++) press(0, 1, 0, "set_min_wrap_no_carry");

      // Full-day wrap from 23:59:59.
      for (int k = 0; k < 23; k++) press(0, 0, 1, "load_hour23");
      while (tm != 59) press(0, 1, 0, "load_min59");
      while (ts != 59) press(1, 0, 0, "load_sec59b");
      step(0, 1, 0, 0, 0, 0, "day_wrap_tick");
      step(0, 0, 0, 0, 0, 0, "day_wrap_one_cycle");
      step(0, 1, 0, 0, 0, 0, "after_wrap_tick");

      // HOUR_MAX = 11 instance: 11 -> 00 in set mode.
      @(negedge clk);
      b_rst = 1'b0; b_mh = 1'b1;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk); b_inc = 1'b1;
         @(negedge clk); b_inc = 1'b0;
         if (k == 9) check_b("hm11_hour10", 2'd1, 4'd0);
      end
      check_b("hm11_hour11", 2'd1, 4'd1);
      @(negedge clk); b_inc = 1'b1;
      @(negedge clk); b_inc = 1'b0;
      check_b("hm11_wrap_to_00", 2'd0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
